key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 8 +
 rtl/key_debounce_fsm.sv | 120 ++++++++++++
 rtl/key_debounce.sv | 34 +++
 tb/tb_key_debounce.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared FSM encoding, counter width and timing defaults for key_debounce.
package key_debounce_pkg;
    localparam int CNT_W               = 10;
    localparam int DEB_MS_DEF          = 20;
    localparam int REPEAT_DELAY_MS_DEF = 500;
    localparam int REPEAT_RATE_MS_DEF  = 100;
    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} key_state_e;
endpackage

// File: rtl/key_debounce_fsm.sv
// key_debounce_fsm: one key channel -- 2-flop synchronizer, debounce FSM and tick counter.
// Auto-repeat in HELD exists only when KEY_DEBOUNCE_REPEAT_EN is defined.
module key_debounce_fsm
    import key_debounce_pkg::*;
#(
    parameter int DEB_MS          = DEB_MS_DEF,
    parameter int REPEAT_DELAY_MS = REPEAT_DELAY_MS_DEF,
    parameter int REPEAT_RATE_MS  = REPEAT_RATE_MS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_MS - 1);
    logic [1:0] sync_q;
    logic ks;
    key_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic level_q, level_d, press_q, press_d, rel_q, rel_d;
    logic deb_done, rep_fire;
    assign ks       = sync_q[1];
    assign deb_done = tick_i && cnt_q == DEB_LAST;
`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_MS - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_MS - 1);
    logic [CNT_W-1:0] rep_q, rep_d;
    logic first_q, first_d;
    logic rep_idle;
    // Any exit from a steady HELD restarts the repeat schedule from the initial delay.
    assign rep_idle = state_q != HELD || !ks;
    assign rep_fire = !rep_idle && tick_i && rep_q == (first_q ? DELAY_LAST : RATE_LAST);
    always_comb begin
        rep_d   = rep_idle ? '0 : rep_fire ? '0 : tick_i ? rep_q + 1'b1 : rep_q;
        first_d = rep_idle ? 1'b1 : rep_fire ? 1'b0 : first_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            rep_q   <= '0;
            first_q <= 1'b1;
        end else begin
            rep_q   <= rep_d;
            first_q <= first_d;
        end
    end
`else
    logic [CNT_W-1:0] unused_rep_cfg;
    assign unused_rep_cfg = CNT_W'(REPEAT_DELAY_MS) ^ CNT_W'(REPEAT_RATE_MS);
    assign rep_fire       = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ks) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!ks) begin
                    state_d = IDLE;
                end else if (deb_done) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else if (tick_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!ks) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end else begin
                    press_d = rep_fire;
                end
            end
            REL_CHK: begin
                if (ks) begin
                    state_d = HELD;
                end else if (deb_done) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else if (tick_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end
    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
endmodule

// File: rtl/key_debounce.sv
// key_debounce: N_KEYS independent debounced key channels with press/release pulses.
// Optional auto-repeat is enabled by defining KEY_DEBOUNCE_REPEAT_EN.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEB_MS          = DEB_MS_DEF,
    parameter int REPEAT_DELAY_MS = REPEAT_DELAY_MS_DEF,
    parameter int REPEAT_RATE_MS  = REPEAT_RATE_MS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1ms,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);
    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_debounce_fsm #(
            .DEB_MS         (DEB_MS),
            .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
            .REPEAT_RATE_MS (REPEAT_RATE_MS)
        ) u_fsm (
            .clk      (clk),
            .reset    (reset),
            .tick_i   (tick_1ms),
            .raw_i    (key_raw[k]),
            .level_o  (key_level[k]),
            .press_o  (key_press[k]),
            .release_o(key_release[k])
        );
    end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scoreboard bench; expected press/release events are queued with the tick
// number after which they must appear, and a negedge monitor pops and compares them.
module tb_key_debounce;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1ms = 1'b0;
    logic [3:0] key_raw = 4'b0000;
    logic [3:0] key_level, key_press, key_release;
    typedef struct {
        int         tick;
        logic [3:0] press;
        logic [3:0] rel;
    } ev_t;
    ev_t  sb[$];
    ev_t  e;
    int   errors = 0;
    int   checks = 0;
    int   tick_no = 0;
    logic tick_seen = 1'b0;

    key_debounce #(
        .N_KEYS(4), .DEB_MS(20), .REPEAT_DELAY_MS(500), .REPEAT_RATE_MS(100)
    ) dut (
        .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .key_raw(key_raw),
        .key_level(key_level), .key_press(key_press), .key_release(key_release)
    );

    always #5 clk = ~clk;

    initial forever begin
        repeat (9) @(negedge clk);
        tick_1ms = 1'b1;
        @(negedge clk);
        tick_1ms = 1'b0;
    end

    always @(posedge clk) begin
        tick_seen <= tick_1ms;
        if (tick_1ms) tick_no <= tick_no + 1;
    end

    // Each pulse must land on the cycle right after its tick's edge, with the exact key masks.
    always @(negedge clk) begin
        if (key_press !== 4'b0000 || key_release !== 4'b0000) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: press=%b release=%b at tick %0d, required no event",
                         key_press, key_release, tick_no);
            end else begin
                e = sb.pop_front();
                if (e.tick !== tick_no || tick_seen !== 1'b1 || e.press !== key_press || e.rel !== key_release) begin
                    errors++;
                    $display("FAIL event: press=%b release=%b at tick %0d (tick edge=%b), required press=%b release=%b at tick %0d (tick edge=1)",
                             key_press, key_release, tick_no, tick_seen, e.press, e.rel, e.tick);
                end
            end
        end else if (sb.size() != 0 && tick_no > sb[0].tick) begin
            checks++;
            errors++;
            e = sb.pop_front();
            $display("FAIL missing_event: nothing seen by tick %0d, required press=%b release=%b at tick %0d",
                     tick_no, e.press, e.rel, e.tick);
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            while (!tick_seen) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if (key_level !== 4'b0000) begin errors++; $display("FAIL reset_level: got %b, required 0000", key_level); end
        checks++;
        if (key_press !== 4'b0000) begin errors++; $display("FAIL reset_press: got %b, required 0000", key_press); end
        checks++;
        if (key_release !== 4'b0000) begin errors++; $display("FAIL reset_release: got %b, required 0000", key_release); end
        reset = 1'b1;
        wait_ticks(2);
    endtask

    task automatic test_clean_press;
        sb.push_back('{tick_no + 20, 4'b0001, 4'b0000});
        key_raw[0] = 1'b1;
        wait_ticks(19);
        checks++;
        if (key_level[0] !== 1'b0) begin errors++; $display("FAIL clean_level_early: got %b, required 0", key_level[0]); end
        wait_ticks(1);
        checks++;
        if (key_level[0] !== 1'b1) begin errors++; $display("FAIL clean_level_on: got %b, required 1", key_level[0]); end
        wait_ticks(5);
        sb.push_back('{tick_no + 20, 4'b0000, 4'b0001});
        key_raw[0] = 1'b0;
        wait_ticks(19);
        checks++;
        if (key_level[0] !== 1'b1) begin errors++; $display("FAIL clean_level_hold: got %b, required 1", key_level[0]); end
        wait_ticks(1);
        checks++;
        if (key_level[0] !== 1'b0) begin errors++; $display("FAIL clean_level_off: got %b, required 0", key_level[0]); end
        wait_ticks(3);
    endtask

    task automatic test_bounce;
        sb.push_back('{tick_no + 32, 4'b0010, 4'b0000});
        key_raw[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ticks(3);
            key_raw[1] = ~key_raw[1];
        end
        wait_ticks(22);
        checks++;
        if (key_level[1] !== 1'b1) begin errors++; $display("FAIL bounce_level: got %b, required 1", key_level[1]); end
        sb.push_back('{tick_no + 20, 4'b0000, 4'b0010});
        key_raw[1] = 1'b0;
        wait_ticks(22);
        checks++;
        if (key_level[1] !== 1'b0) begin errors++; $display("FAIL bounce_release_level: got %b, required 0", key_level[1]); end
    endtask

    task automatic test_release_glitch;
        sb.push_back('{tick_no + 20, 4'b0100, 4'b0000});
        key_raw[2] = 1'b1;
        wait_ticks(25);
        key_raw[2] = 1'b0;
        wait_ticks(5);
        checks++;
        if (key_level[2] !== 1'b1) begin errors++; $display("FAIL glitch_level_low: got %b, required 1", key_level[2]); end
        key_raw[2] = 1'b1;
        wait_ticks(25);
        checks++;
        if (key_level[2] !== 1'b1) begin errors++; $display("FAIL glitch_level_after: got %b, required 1", key_level[2]); end
        sb.push_back('{tick_no + 20, 4'b0000, 4'b0100});
        key_raw[2] = 1'b0;
        wait_ticks(22);
        checks++;
        if (key_level[2] !== 1'b0) begin errors++; $display("FAIL glitch_release_level: got %b, required 0", key_level[2]); end
    endtask

    task automatic test_reset_mid_debounce;
        sb.push_back('{tick_no + 20, 4'b1000, 4'b0000});
        key_raw[3] = 1'b1;
        wait_ticks(22);
        key_raw[0] = 1'b1;
        wait_ticks(10);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (key_level !== 4'b0000) begin errors++; $display("FAIL midreset_level: got %b, required 0000", key_level); end
        checks++;
        if (key_press !== 4'b0000 || key_release !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_pulses: got press=%b release=%b, required 0000/0000", key_press, key_release);
        end
        reset = 1'b1;
        sb.push_back('{tick_no + 20, 4'b1001, 4'b0000});
        wait_ticks(22);
        checks++;
        if (key_level !== 4'b1001) begin errors++; $display("FAIL midreset_level_after: got %b, required 1001", key_level); end
        sb.push_back('{tick_no + 20, 4'b0000, 4'b1001});
        key_raw = 4'b0000;
        wait_ticks(22);
    endtask

    task automatic test_back_to_back;
        sb.push_back('{tick_no + 20, 4'b1001, 4'b0000});
        key_raw = 4'b1001;
        wait_ticks(22);
        checks++;
        if (key_level !== 4'b1001) begin errors++; $display("FAIL concurrent_level: got %b, required 1001", key_level); end
        sb.push_back('{tick_no + 20, 4'b0000, 4'b1001});
        key_raw = 4'b0000;
        wait_ticks(22);
    endtask

    task automatic test_repeat;
        int t0;
        t0 = tick_no;
        sb.push_back('{t0 + 20, 4'b0010, 4'b0000});
`ifdef KEY_DEBOUNCE_REPEAT_EN
        sb.push_back('{t0 + 520, 4'b0010, 4'b0000});
        sb.push_back('{t0 + 620, 4'b0010, 4'b0000});
        sb.push_back('{t0 + 720, 4'b0010, 4'b0000});
`endif
        key_raw[1] = 1'b1;
        wait_ticks(800);
        checks++;
        if (key_level[1] !== 1'b1) begin errors++; $display("FAIL repeat_level: got %b, required 1", key_level[1]); end
        sb.push_back('{tick_no + 20, 4'b0000, 4'b0010});
        key_raw[1] = 1'b0;
        wait_ticks(22);
        checks++;
        if (key_level[1] !== 1'b0) begin errors++; $display("FAIL repeat_release_level: got %b, required 0", key_level[1]); end
    endtask

    task automatic test_drained;
        wait_ticks(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: %0d events outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_bounce;
        test_release_glitch;
        test_reset_mid_debounce;
        test_back_to_back;
        test_repeat;
        test_drained;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required test sequence to complete");
        $fatal(1, "watchdog");
    end
endmodule
